memory_responder: RTL

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : memory_responder
// Purpose  : Single-port 16-bit word memory that answers CPU read/write
//            request levels after a fixed, parameterised latency, with a
//            one-cycle completion strobe and a release handshake so a held
//            request never starts a second access.
// Ports    : clk          - rising-edge clock
//            reset_n      - synchronous active-low reset (array not cleared)
//            read_m       - read request level
//            write_m      - write request level (read wins if both high)
//            address[15:0]- word address, low ADDR_W bits used (wraps)
//            data_in[15:0]- write data
//            data_out     - registered read data, held until next read
//            input_ready  - one-cycle strobe: read complete
//            ack_output   - one-cycle strobe: write committed
//            busy         - high whenever the FSM is not IDLE
// Params   : ADDR_W  - array index width (2**ADDR_W words), 1..16
//            LATENCY - capture-to-strobe edges, 1..15
// Revision : 1.0 - initial release
// ============================================================================
module memory_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        read_m,
  input  logic        write_m,
  input  logic [15:0] address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        input_ready,
  output logic        ack_output,
  output logic        busy
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_WAIT    = 2'd1;
  localparam logic [1:0] c_RESP    = 2'd2;
  localparam logic [1:0] c_RELEASE = 2'd3;

  // Counter preload: the WAIT->RESP edge is the one where the counter is 0,
  // so LATENCY-1 preload places the strobe LATENCY edges after capture.
  localparam logic [3:0] c_LOAD = 4'(LATENCY - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [3:0]        r_cnt;
  logic              r_is_rd;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_data;
  logic [15:0]       r_dout;
  logic [15:0]       r_mem [2**ADDR_W];

  logic w_req;
  logic w_fire;

  assign w_req  = read_m | write_m;
  assign w_fire = (r_state == c_WAIT) && (r_cnt == 4'd0);

  // Upper address bits are intentionally ignored so addresses wrap.
  generate
    if (ADDR_W < 16) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^address[15:ADDR_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:    if (w_req)              w_next = c_WAIT;
      c_WAIT:    if (r_cnt == 4'd0)      w_next = c_RESP;
      c_RESP:    w_next = w_req ? c_RELEASE : c_IDLE;
      c_RELEASE: if (!w_req)             w_next = c_IDLE;
      default:   w_next = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: strobes are decoded from RESP so they last one cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    input_ready = (r_state == c_RESP) &&  r_is_rd;
    ack_output  = (r_state == c_RESP) && !r_is_rd;
    busy        = (r_state != c_IDLE);
  end

  assign data_out = r_dout;

  // --------------------------------------------------------------------------
  // Request capture, latency counter and read data register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt  <= 4'd0;
      r_dout <= 16'h0000;
    end else begin
      if ((r_state == c_IDLE) && w_req) begin
        // Read takes priority when both request levels are high.
        r_is_rd <= read_m;
        r_addr  <= address[ADDR_W-1:0];
        r_data  <= data_in;
        r_cnt   <= c_LOAD;
      end else if ((r_state == c_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_fire && r_is_rd) begin
        r_dout <= r_mem[r_addr];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Array write port. Not reset; a reset during WAIT suppresses the commit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset_n && w_fire && !r_is_rd) begin
      r_mem[r_addr] <= r_data;
    end
  end

endmodule
`default_nettype wire
